// File: rtl/alu_divider_if.sv
// Handshake and result bundle between the control unit and the DIV unit.
// The control unit drives start/a/b and reads busy/done and the HI/LO results.
interface alu_divider_if #(
    parameter int BITS = 32
);
    logic            start;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic            busy;
    logic            done;
    logic [BITS-1:0] hi;
    logic [BITS-1:0] lo;
    logic            div_by_zero;

    modport master (
        output start, a, b,
        input  busy, done, hi, lo, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/alu_divider.sv
// Signed restoring divider: one quotient bit per clock on operand magnitudes,
// with sign fix-up in a final cycle. Quotient goes to LO, remainder to HI.
module alu_divider #(
    parameter int BITS = 32
) (
    input  logic          clk,
    input  logic          clr,
    alu_divider_if.slave  bus
);
    localparam int CW = $clog2(BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [BITS-1:0] rem_r, rem_s;
    logic [BITS-1:0] dvd_r, dvd_s;
    logic [BITS-1:0] dvs_r, dvs_s;
    logic            sign_q_r, sign_q_s;
    logic            sign_r_r, sign_r_s;
    logic            bzero_r, bzero_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic            dbz_r, dbz_s;
    logic [BITS-1:0] hi_r, hi_s;
    logic [BITS-1:0] lo_r, lo_s;
    logic [BITS:0]   shift_s;
    logic [BITS:0]   trial_s;

    // Magnitude of a two's complement value; the most negative value maps to itself as unsigned.
    function automatic logic [BITS-1:0] magnitude(input logic [BITS-1:0] v);
        if (v[BITS-1]) begin
            magnitude = -v;
        end else begin
            magnitude = v;
        end
    endfunction

    // Next-state, datapath step and result fix-up.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        rem_s    = rem_r;
        dvd_s    = dvd_r;
        dvs_s    = dvs_r;
        sign_q_s = sign_q_r;
        sign_r_s = sign_r_r;
        bzero_s  = bzero_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        dbz_s    = dbz_r;
        hi_s     = hi_r;
        lo_s     = lo_r;
        // Remainder stays below |b| <= 2^(BITS-1), so BITS+1 bits hold the shifted trial exactly.
        shift_s  = {rem_r, dvd_r[BITS-1]};
        trial_s  = shift_s - {1'b0, dvs_r};

        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    dvd_s    = magnitude(bus.a);
                    dvs_s    = magnitude(bus.b);
                    sign_q_s = bus.a[BITS-1] ^ bus.b[BITS-1];
                    sign_r_s = bus.a[BITS-1];
                    bzero_s  = (bus.b == {BITS{1'b0}});
                    rem_s    = {BITS{1'b0}};
                    cnt_s    = CNT_LAST;
                    busy_s   = 1'b1;
                    state_s  = CALC;
                end else begin
                    state_s  = IDLE;
                end
            end
            CALC: begin
                if (trial_s[BITS]) begin
                    rem_s = shift_s[BITS-1:0];
                end else begin
                    rem_s = trial_s[BITS-1:0];
                end
                dvd_s = {dvd_r[BITS-2:0], ~trial_s[BITS]};
                if (cnt_r == CNT_ZERO) begin
                    state_s = FIX;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                end
            end
            FIX: begin
                // With a zero divisor every trial succeeds, leaving rem = |a|, so HI rebuilds a.
                if (bzero_r) begin
                    lo_s = {BITS{1'b1}};
                end else if (sign_q_r) begin
                    lo_s = -dvd_r;
                end else begin
                    lo_s = dvd_r;
                end
                if (sign_r_r) begin
                    hi_s = -rem_r;
                end else begin
                    hi_s = rem_r;
                end
                dbz_s   = bzero_r;
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; clr aborts any division in flight.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            rem_r    <= {BITS{1'b0}};
            dvd_r    <= {BITS{1'b0}};
            dvs_r    <= {BITS{1'b0}};
            sign_q_r <= 1'b0;
            sign_r_r <= 1'b0;
            bzero_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
            hi_r     <= {BITS{1'b0}};
            lo_r     <= {BITS{1'b0}};
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            rem_r    <= rem_s;
            dvd_r    <= dvd_s;
            dvs_r    <= dvs_s;
            sign_q_r <= sign_q_s;
            sign_r_r <= sign_r_s;
            bzero_r  <= bzero_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            dbz_r    <= dbz_s;
            hi_r     <= hi_s;
            lo_r     <= lo_s;
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
    assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_alu_divider.sv
// Self-checking bench for alu_divider: directed sign/edge cases, busy and reset
// behaviour, back-to-back issue, then random operands against signed arithmetic.
module tb_alu_divider;
    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    alu_divider_if #(.BITS(32)) bus();
    alu_divider #(.BITS(32)) dut (.clk(clk), .clr(clr), .bus(bus));

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_lo  = 32'h0;
    logic [31:0] last_hi  = 32'h0;
    logic        last_dbz = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: truncating signed division, remainder follows the dividend.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic z);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        z  = 1'b0;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    // Present operands with start for one edge; called away from the rising edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    // Wait for done (bounded), checking busy/hold behaviour and the result.
    task automatic finish_div(input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [31:0] q, r;
        logic z;
        int n = 0;
        int busy_bad = 0;
        int hold_bad = 0;
        int both_hi  = 0;
        ref_div(a, b, q, r, z);
        while (bus.done !== 1'b1 && n < 40) begin
            if (poke && n == 10) begin
                bus.a = 32'd9; bus.b = 32'd2; bus.start = 1'b1;
            end
            if (poke && n == 11) bus.start = 1'b0;
            if (bus.busy !== 1'b1) busy_bad++;
            if (bus.lo !== last_lo || bus.hi !== last_hi || bus.div_by_zero !== last_dbz) hold_bad++;
            @(posedge clk);
            #1;
            n++;
        end
        bus.start = 1'b0;
        check("latency", 32'(n), 32'd33);
        check("busy_during_calc", 32'(busy_bad), 32'd0);
        check("hold_during_calc", 32'(hold_bad), 32'd0);
        if (bus.busy === 1'b1 && bus.done === 1'b1) both_hi = 1;
        check("busy_done_overlap", 32'(both_hi), 32'd0);
        check("lo", bus.lo, q);
        check("hi", bus.hi, r);
        check("div_by_zero", 32'(bus.div_by_zero), 32'(z));
        last_lo  = q;
        last_hi  = r;
        last_dbz = z;
    endtask

    // Step idle cycles and confirm no done appears.
    task automatic idle_check(input int cycles, input string tag);
        int extra = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) extra++;
        end
        check(tag, 32'(extra), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h0;
            1: v = 32'h8000_0000;
            2: v = 32'($urandom_range(0, 20));
            3: v = -32'($urandom_range(1, 20));
            4: v = 32'hFFFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    logic [31:0] da [7] = '{32'd124, 32'hFFFF_FF84, 32'd124,     32'hFFFF_FF84,
                            32'h8000_0000, 32'd0, 32'd5};
    logic [31:0] db [7] = '{32'd7,   32'd7,        32'hFFFF_FFF9, 32'hFFFF_FFF9,
                            32'hFFFF_FFFF, 32'd5, 32'd124};

    initial begin
        bus.start = 1'b0;
        bus.a     = 32'h0;
        bus.b     = 32'h0;
        #1 clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        clr = 1'b0;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            launch(da[i], db[i]);
            finish_div(da[i], db[i], 1'b0);
            idle_check(1, "done_single_cycle");
        end

        // Divide by zero, then back-to-back 10/3 issued during the done cycle.
        @(negedge clk);
        launch(32'h1234, 32'h0);
        finish_div(32'h1234, 32'h0, 1'b0);
        launch(32'd10, 32'd3);
        finish_div(32'd10, 32'd3, 1'b0);
        check("dbz_cleared_lo", bus.lo, 32'd3);

        // Start pulse and operand change while busy must be ignored.
        idle_check(2, "gap_no_done");
        launch(32'd124, 32'd7);
        finish_div(32'd124, 32'd7, 1'b1);
        idle_check(40, "no_second_done");

        // Asynchronous clear mid-operation.
        launch(32'd124, 32'd7);
        repeat (14) @(posedge clk);
        #2 clr = 1'b1;
        #1;
        check("clr_busy", 32'(bus.busy), 32'd0);
        check("clr_done", 32'(bus.done), 32'd0);
        check("clr_hi", bus.hi, 32'h0);
        check("clr_lo", bus.lo, 32'h0);
        last_lo = 32'h0; last_hi = 32'h0; last_dbz = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        idle_check(40, "no_done_after_clr");
        launch(32'd100, 32'd9);
        finish_div(32'd100, 32'd9, 1'b0);

        // Random operands, mostly back-to-back.
        for (int i = 0; i < 30; i++) begin
            logic [31:0] ra, rb;
            ra = pick();
            rb = pick();
            launch(ra, rb);
            finish_div(ra, rb, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
